// File: rtl/shell_pkg.sv
// Shared types and helpers for the tank shell pool: direction encoding, pool depth,
// default map size and the one-step neighbour computation.
package shell_pkg;

  localparam int unsigned NUM_SHELLS    = 5;
  localparam int unsigned DEFAULT_MAP_W = 64;
  localparam int unsigned DEFAULT_MAP_H = 48;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  // Returns {in_bounds, nx, ny}. The step is taken in 7 bits so that 0-1 becomes 127
  // and fails the bounds test instead of wrapping onto the far edge.
  function automatic logic [12:0] next_cell(input logic [5:0] x, input logic [5:0] y,
                                            input dir_t dir,
                                            input int unsigned map_w = DEFAULT_MAP_W,
                                            input int unsigned map_h = DEFAULT_MAP_H);
    logic [6:0] ex;
    logic [6:0] ey;
    logic       in_b;
    ex = {1'b0, x};
    ey = {1'b0, y};
    unique case (dir)
      DIR_UP:    ey = ey - 7'd1;
      DIR_RIGHT: ex = ex + 7'd1;
      DIR_DOWN:  ey = ey + 7'd1;
      DIR_LEFT:  ex = ex - 7'd1;
      default:   ;
    endcase
    in_b = (32'(ex) < map_w) && (32'(ey) < map_h);
    return {in_b, ex[5:0], ey[5:0]};
  endfunction

endpackage

// File: rtl/shell_slot.sv
// One shell slot: valid/position/direction registers with reset > hit > spawn > move
// priority. Shells leaving the map retire in place.
module shell_slot
  import shell_pkg::*;
#(
  parameter int unsigned MapW = DEFAULT_MAP_W,
  parameter int unsigned MapH = DEFAULT_MAP_H
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       spawn_i,
  input  logic [5:0] spawn_x_i,
  input  logic [5:0] spawn_y_i,
  input  logic [1:0] spawn_dir_i,
  input  logic       hit_i,
  input  logic       move_i,
  output logic       valid_o,
  output logic [5:0] x_o,
  output logic [5:0] y_o
);

  logic        valid_q, valid_d;
  logic [5:0]  x_q, x_d;
  logic [5:0]  y_q, y_d;
  dir_t        dir_q, dir_d;
  logic [12:0] step;

  always_comb begin
    valid_d = valid_q;
    x_d     = x_q;
    y_d     = y_q;
    dir_d   = dir_q;
    step    = next_cell(x_q, y_q, dir_q, MapW, MapH);
    // A hit on an empty slot is ignored, so it cannot block a spawn into that slot.
    if (hit_i && valid_q) begin
      valid_d = 1'b0;
    end else if (spawn_i) begin
      valid_d = 1'b1;
      x_d     = spawn_x_i;
      y_d     = spawn_y_i;
      dir_d   = dir_t'(spawn_dir_i);
    end else if (move_i && valid_q) begin
      if (step[12]) begin
        x_d = step[11:6];
        y_d = step[5:0];
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      dir_q   <= DIR_UP;
    end else begin
      valid_q <= valid_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dir_q   <= dir_d;
    end
  end

  assign valid_o = valid_q;
  assign x_o     = x_q;
  assign y_o     = y_q;

endmodule

// File: rtl/shell_controller.sv
// Shell pool for one tank: fire acceptance, lowest-free-slot allocation, cooldown and
// fire acknowledge, around NUM_SHELLS shell_slot instances.
module shell_controller
  import shell_pkg::*;
#(
  parameter int unsigned MAP_W    = DEFAULT_MAP_W,
  parameter int unsigned MAP_H    = DEFAULT_MAP_H,
  parameter int unsigned COOLDOWN = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_fire,
  input  logic [5:0] i_tank_x,
  input  logic [5:0] i_tank_y,
  input  logic [1:0] i_tank_dir,
  input  logic       i_move_tick,
  input  logic [4:0] i_hit,
  output logic [5:0] o_shell_0_x,
  output logic [5:0] o_shell_0_y,
  output logic [5:0] o_shell_1_x,
  output logic [5:0] o_shell_1_y,
  output logic [5:0] o_shell_2_x,
  output logic [5:0] o_shell_2_y,
  output logic [5:0] o_shell_3_x,
  output logic [5:0] o_shell_3_y,
  output logic [5:0] o_shell_4_x,
  output logic [5:0] o_shell_4_y,
  output logic [4:0] o_shell_valid,
  output logic       o_fire_ack,
  output logic       o_full
);

  localparam int unsigned CntW = $clog2(COOLDOWN + 2);

  logic [NUM_SHELLS-1:0] valid;
  logic [NUM_SHELLS-1:0] free;
  logic [NUM_SHELLS-1:0] alloc_oh;
  logic [NUM_SHELLS-1:0] spawn;
  logic [5:0]            slot_x [NUM_SHELLS];
  logic [5:0]            slot_y [NUM_SHELLS];
  logic [12:0]           spawn_cell;
  logic                  fire_ok;
  logic [CntW-1:0]       cooldown_q, cooldown_d;
  logic                  fire_ack_q;

  // Free slots come from the registered valid vector, so a slot freed by a hit this
  // cycle is only allocatable next cycle.
  assign free     = ~valid;
  assign alloc_oh = free & (~free + 1'b1);

  always_comb begin
    spawn_cell = next_cell(i_tank_x, i_tank_y, dir_t'(i_tank_dir), MAP_W, MAP_H);
    fire_ok    = i_fire && (cooldown_q == '0) && (|free) && spawn_cell[12];
    spawn      = fire_ok ? alloc_oh : '0;
  end

  always_comb begin
    cooldown_d = cooldown_q;
    if (fire_ok) begin
      cooldown_d = CntW'(COOLDOWN);
    end else if (i_move_tick && (cooldown_q != '0)) begin
      cooldown_d = cooldown_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cooldown_q <= '0;
      fire_ack_q <= 1'b0;
    end else begin
      cooldown_q <= cooldown_d;
      fire_ack_q <= fire_ok;
    end
  end

  for (genvar k = 0; k < NUM_SHELLS; k++) begin : g_slot
    shell_slot #(
      .MapW (MAP_W),
      .MapH (MAP_H)
    ) u_slot (
      .clk_i       (i_clk),
      .rst_ni      (i_rst_n),
      .spawn_i     (spawn[k]),
      .spawn_x_i   (spawn_cell[11:6]),
      .spawn_y_i   (spawn_cell[5:0]),
      .spawn_dir_i (i_tank_dir),
      .hit_i       (i_hit[k]),
      .move_i      (i_move_tick),
      .valid_o     (valid[k]),
      .x_o         (slot_x[k]),
      .y_o         (slot_y[k])
    );
  end

  assign o_shell_0_x   = slot_x[0];
  assign o_shell_0_y   = slot_y[0];
  assign o_shell_1_x   = slot_x[1];
  assign o_shell_1_y   = slot_y[1];
  assign o_shell_2_x   = slot_x[2];
  assign o_shell_2_y   = slot_y[2];
  assign o_shell_3_x   = slot_x[3];
  assign o_shell_3_y   = slot_y[3];
  assign o_shell_4_x   = slot_x[4];
  assign o_shell_4_y   = slot_y[4];
  assign o_shell_valid = valid;
  assign o_fire_ack    = fire_ack_q;
  assign o_full        = &valid;

endmodule

// File: tb/tb_shell_controller.sv
// Directed bench for shell_controller: expectations are queued before each clock and
// checked against the registered outputs just after it.
module tb_shell_controller;

  logic       clk;
  logic       rst_n;
  logic       fire;
  logic [5:0] tank_x;
  logic [5:0] tank_y;
  logic [1:0] tank_dir;
  logic       move_tick;
  logic [4:0] hit;

  logic [5:0] ax [5];
  logic [5:0] ay [5];
  logic [4:0] a_valid;
  logic       a_ack;
  logic       a_full;
  logic [5:0] bx [5];
  logic [5:0] by [5];
  logic [4:0] b_valid;
  logic       b_ack;
  logic       b_full;

  typedef struct {
    string       tag;
    bit          sel;
    int          slot;
    logic [18:0] exp;
  } chk_t;

  chk_t sb[$];
  int   checks;
  int   errors;

  shell_controller dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_fire        (fire),
    .i_tank_x      (tank_x),
    .i_tank_y      (tank_y),
    .i_tank_dir    (tank_dir),
    .i_move_tick   (move_tick),
    .i_hit         (hit),
    .o_shell_0_x   (ax[0]),
    .o_shell_0_y   (ay[0]),
    .o_shell_1_x   (ax[1]),
    .o_shell_1_y   (ay[1]),
    .o_shell_2_x   (ax[2]),
    .o_shell_2_y   (ay[2]),
    .o_shell_3_x   (ax[3]),
    .o_shell_3_y   (ay[3]),
    .o_shell_4_x   (ax[4]),
    .o_shell_4_y   (ay[4]),
    .o_shell_valid (a_valid),
    .o_fire_ack    (a_ack),
    .o_full        (a_full)
  );

  shell_controller #(
    .COOLDOWN (0)
  ) dut0 (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_fire        (fire),
    .i_tank_x      (tank_x),
    .i_tank_y      (tank_y),
    .i_tank_dir    (tank_dir),
    .i_move_tick   (move_tick),
    .i_hit         (hit),
    .o_shell_0_x   (bx[0]),
    .o_shell_0_y   (by[0]),
    .o_shell_1_x   (bx[1]),
    .o_shell_1_y   (by[1]),
    .o_shell_2_x   (bx[2]),
    .o_shell_2_y   (by[2]),
    .o_shell_3_x   (bx[3]),
    .o_shell_3_y   (by[3]),
    .o_shell_4_x   (bx[4]),
    .o_shell_4_y   (by[4]),
    .o_shell_valid (b_valid),
    .o_fire_ack    (b_ack),
    .o_full        (b_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {valid, ack, full, x, y} of one slot of the selected instance
  function automatic logic [18:0] observe(input bit sel, input int slot);
    if (!sel) return {a_valid, a_ack, a_full, ax[slot], ay[slot]};
    return {b_valid, b_ack, b_full, bx[slot], by[slot]};
  endfunction

  task automatic expect_state(input string tag, input bit sel, input logic [4:0] v,
                              input logic ack, input logic full, input int slot,
                              input logic [5:0] x, input logic [5:0] y);
    chk_t c;
    c.tag  = tag;
    c.sel  = sel;
    c.slot = slot;
    c.exp  = {v, ack, full, x, y};
    sb.push_back(c);
  endtask

  task automatic tick();
    chk_t        c;
    logic [18:0] o;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      c = sb.pop_front();
      o = observe(c.sel, c.slot);
      checks++;
      assert (o === c.exp) else begin
        errors++;
        $error("FAIL %s slot%0d: observed {v,ack,full,x,y}=%b_%b_%b_%0d_%0d required %b_%b_%b_%0d_%0d",
               c.tag, c.slot, o[18:14], o[13], o[12], o[11:6], o[5:0],
               c.exp[18:14], c.exp[13], c.exp[12], c.exp[11:6], c.exp[5:0]);
      end
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    fire      = 1'b0;
    tank_x    = 6'd10;
    tank_y    = 6'd10;
    tank_dir  = 2'd1;
    move_tick = 1'b0;
    hit       = 5'b0;

    for (int k = 0; k < 5; k++) expect_state("reset", 0, 5'b0, 0, 0, k, 6'd0, 6'd0);
    tick();

    // First fire, then cooldown holds off a held fire across three ticks and one more.
    rst_n = 1'b1;
    fire  = 1'b1;
    expect_state("fire0", 0, 5'b00001, 1, 0, 0, 6'd11, 6'd10);
    tick();
    expect_state("cd_hold", 0, 5'b00001, 0, 0, 0, 6'd11, 6'd10);
    tick();
    move_tick = 1'b1;
    expect_state("move1", 0, 5'b00001, 0, 0, 0, 6'd12, 6'd10);
    tick();
    expect_state("move2", 0, 5'b00001, 0, 0, 0, 6'd13, 6'd10);
    tick();
    expect_state("move3", 0, 5'b00001, 0, 0, 0, 6'd14, 6'd10);
    tick();
    move_tick = 1'b0;
    expect_state("cd1_rej", 0, 5'b00001, 0, 0, 0, 6'd14, 6'd10);
    tick();
    move_tick = 1'b1;
    expect_state("cd_edge_rej", 0, 5'b00001, 0, 0, 0, 6'd15, 6'd10);
    tick();
    move_tick = 1'b0;
    expect_state("refire", 0, 5'b00011, 1, 0, 1, 6'd11, 6'd10);
    tick();
    fire = 1'b0;

    // Let cooldown expire.
    move_tick = 1'b1;
    repeat (3) tick();
    expect_state("drain", 0, 5'b00011, 0, 0, 0, 6'd19, 6'd10);
    tick();

    // Map edges: spawn off the left edge is rejected, a shell leaves the right edge.
    move_tick = 1'b0;
    tank_x    = 6'd0;
    tank_y    = 6'd5;
    tank_dir  = 2'd3;
    fire      = 1'b1;
    expect_state("oob_rej", 0, 5'b00011, 0, 0, 0, 6'd19, 6'd10);
    tick();
    tank_x   = 6'd61;
    tank_dir = 2'd1;
    expect_state("edge_spawn", 0, 5'b00111, 1, 0, 2, 6'd62, 6'd5);
    tick();
    fire      = 1'b0;
    move_tick = 1'b1;
    expect_state("edge_63", 0, 5'b00111, 0, 0, 2, 6'd63, 6'd5);
    tick();
    expect_state("edge_retire", 0, 5'b00011, 0, 0, 2, 6'd63, 6'd5);
    tick();

    // Hit and move on the same slot.
    hit = 5'b00001;
    expect_state("hit_move", 0, 5'b00010, 0, 0, 1, 6'd18, 6'd10);
    expect_state("hit_hold", 0, 5'b00010, 0, 0, 0, 6'd21, 6'd10);
    tick();
    hit = 5'b0;
    tick();

    // Fire on a move tick: new shell not stepped, existing shell steps.
    tank_x   = 6'd10;
    tank_y   = 6'd10;
    tank_dir = 2'd2;
    fire     = 1'b1;
    expect_state("fire_on_tick", 0, 5'b00011, 1, 0, 0, 6'd10, 6'd11);
    expect_state("others_step", 0, 5'b00011, 1, 0, 1, 6'd20, 6'd10);
    tick();
    fire = 1'b0;
    repeat (4) tick();

    // Third live shell, then reset mid-flight with cooldown at 2.
    move_tick = 1'b0;
    tank_dir  = 2'd0;
    fire      = 1'b1;
    expect_state("third", 0, 5'b00111, 1, 0, 2, 6'd10, 6'd9);
    tick();
    fire      = 1'b0;
    move_tick = 1'b1;
    tick();
    expect_state("pre_reset", 0, 5'b00111, 0, 0, 2, 6'd10, 6'd7);
    tick();
    move_tick = 1'b0;
    rst_n     = 1'b0;
    fire      = 1'b1;
    for (int k = 0; k < 5; k++) expect_state("mid_reset", 0, 5'b0, 0, 0, k, 6'd0, 6'd0);
    tick();
    rst_n    = 1'b1;
    tank_dir = 2'd1;
    expect_state("post_reset_fire", 0, 5'b00001, 1, 0, 0, 6'd11, 6'd10);
    tick();

    // Fill the zero-cooldown instance.
    fire  = 1'b0;
    rst_n = 1'b0;
    expect_state("reset_b", 1, 5'b0, 0, 0, 0, 6'd0, 6'd0);
    tick();
    rst_n = 1'b1;
    fire  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      expect_state("fill", 1, 5'((1 << (k + 1)) - 1), 1, (k == 4), k, 6'd11, 6'd10);
      tick();
    end
    expect_state("full_rej", 1, 5'b11111, 0, 1, 4, 6'd11, 6'd10);
    tick();
    hit = 5'b00100;
    expect_state("hit_fire_rej", 1, 5'b11011, 0, 0, 2, 6'd11, 6'd10);
    tick();
    hit = 5'b0;
    expect_state("realloc", 1, 5'b11111, 1, 1, 2, 6'd11, 6'd10);
    tick();
    fire = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
